// File: rtl/matmul_host_streamer.sv
// Host-side streamer for the matmul accelerator: serialises A/B operands onto
// the accelerator pins, fires finish, and collects C words into a result stream.
module matmul_host_streamer #(
    parameter int MAX_M          = 100,
    parameter int MAX_K          = 100,
    parameter int MAX_N          = 100,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [$clog2(MAX_M):0] M_cfg,
    input  logic [$clog2(MAX_K):0] K_cfg,
    input  logic [$clog2(MAX_N):0] N_cfg,
    input  logic                   in_valid,
    input  logic [31:0]            in_data,
    output logic                   in_ready,
    output logic [$clog2(MAX_M):0] acc_M,
    output logic [$clog2(MAX_K):0] acc_K,
    output logic [$clog2(MAX_N):0] acc_N,
    output logic [31:0]            acc_serial_in,
    output logic [1:0]             acc_mode,
    input  logic [31:0]            acc_serial_out,
    input  logic                   acc_active,
    input  logic                   acc_done,
    output logic                   res_valid,
    output logic [31:0]            res_data,
    output logic                   res_last,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int MW = $clog2(MAX_M) + 1;
    localparam int KW = $clog2(MAX_K) + 1;
    localparam int NW = $clog2(MAX_N) + 1;
    localparam int AW = $clog2(MAX_M * MAX_K + 1);
    localparam int BW = $clog2(MAX_K * MAX_N + 1);
    localparam int RW = $clog2(MAX_M * MAX_N + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_FINISH, S_WAIT_C, S_DRAIN, S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] mk_q, a_cnt;
    logic [BW-1:0] kn_q, b_cnt;
    logic [RW-1:0] mn_q, r_cnt;
    logic [TW-1:0] idle_cnt;
    logic [RW:0]   cap_cnt;
    logic          dims_ok, timeout;

    logic [31:0] sin_nx, rd_nx;
    logic [1:0]  mode_nx;
    logic        rv_nx, rl_nx, done_nx, err_nx;

    assign dims_ok = (M_cfg != '0) && (M_cfg <= MW'(MAX_M))
                  && (K_cfg != '0) && (K_cfg <= KW'(MAX_K))
                  && (N_cfg != '0) && (N_cfg <= NW'(MAX_N));

    assign timeout  = !acc_active && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign cap_cnt  = {1'b0, r_cnt} + {{RW{1'b0}}, acc_active};
    assign in_ready = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:
                if (start && dims_ok) state_nx = S_LOAD_A;
            S_LOAD_A:
                if (in_valid && a_cnt == mk_q - AW'(1)) state_nx = S_LOAD_B;
            S_LOAD_B:
                if (in_valid && b_cnt == kn_q - BW'(1)) state_nx = S_FINISH;
            S_FINISH:
                state_nx = S_WAIT_C;
            S_WAIT_C, S_DRAIN:
                if (acc_done || timeout) state_nx = S_DONE;
                else if (acc_active)     state_nx = S_DRAIN;
            S_DONE:
                state_nx = S_IDLE;
            default:
                state_nx = S_IDLE;
        endcase
    end

    // Next values of the registered pin/stream outputs.
    always_comb begin
        mode_nx = 2'b00;
        sin_nx  = acc_serial_in;
        rv_nx   = 1'b0;
        rd_nx   = res_data;
        rl_nx   = 1'b0;
        done_nx = 1'b0;
        err_nx  = 1'b0;
        unique case (state)
            S_IDLE:
                err_nx = start && !dims_ok;
            S_LOAD_A:
                if (in_valid) begin
                    mode_nx = 2'b01;
                    sin_nx  = in_data;
                end
            S_LOAD_B:
                if (in_valid) begin
                    mode_nx = 2'b10;
                    sin_nx  = in_data;
                end
            S_FINISH: begin
                mode_nx = 2'b11;
                sin_nx  = '0;
            end
            S_WAIT_C, S_DRAIN: begin
                if (acc_active) begin
                    rv_nx = 1'b1;
                    rd_nx = acc_serial_out;
                    rl_nx = (r_cnt == mn_q - RW'(1));
                end
                if (acc_done) begin
                    done_nx = 1'b1;
                    err_nx  = (cap_cnt != {1'b0, mn_q});
                end else if (timeout) begin
                    done_nx = 1'b1;
                    err_nx  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_serial_in <= '0;
            acc_mode      <= 2'b00;
            res_valid     <= 1'b0;
            res_data      <= '0;
            res_last      <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            acc_serial_in <= sin_nx;
            acc_mode      <= mode_nx;
            res_valid     <= rv_nx;
            res_data      <= rd_nx;
            res_last      <= rl_nx;
            done          <= done_nx;
            err           <= err_nx;
        end
    end

    // Dimensions and their products are frozen at start for the whole job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_M    <= '0;
            acc_K    <= '0;
            acc_N    <= '0;
            mk_q     <= '0;
            kn_q     <= '0;
            mn_q     <= '0;
            a_cnt    <= '0;
            b_cnt    <= '0;
            r_cnt    <= '0;
            idle_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE:
                    if (start) begin
                        acc_M    <= M_cfg;
                        acc_K    <= K_cfg;
                        acc_N    <= N_cfg;
                        mk_q     <= AW'(M_cfg) * AW'(K_cfg);
                        kn_q     <= BW'(K_cfg) * BW'(N_cfg);
                        mn_q     <= RW'(M_cfg) * RW'(N_cfg);
                        a_cnt    <= '0;
                        b_cnt    <= '0;
                        r_cnt    <= '0;
                        idle_cnt <= '0;
                    end
                S_LOAD_A:
                    if (in_valid) a_cnt <= a_cnt + AW'(1);
                S_LOAD_B:
                    if (in_valid) b_cnt <= b_cnt + BW'(1);
                S_WAIT_C, S_DRAIN:
                    if (acc_active) begin
                        r_cnt    <= r_cnt + RW'(1);
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_host_streamer.sv
// Testbench for matmul_host_streamer: table of jobs plus random jobs, checked
// against a matrix-multiply model and a behavioural accelerator stand-in.
module tb_matmul_host_streamer;

    localparam int MX = 4;
    localparam int TO = 16;
    localparam int DW = $clog2(MX) + 1;

    localparam int NORM  = 0;
    localparam int DLAST = 1;
    localparam int SHORT = 2;
    localparam int EXTRA = 3;
    localparam int TOUT  = 4;
    localparam int REJ   = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] m_cfg = '0, k_cfg = '0, n_cfg = '0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_data = '0;
    logic          in_ready;
    logic [DW-1:0] acc_m, acc_k, acc_n;
    logic [31:0]   acc_serial_in;
    logic [1:0]    acc_mode;
    logic [31:0]   acc_serial_out = '0;
    logic          acc_active = 1'b0, acc_done = 1'b0;
    logic          res_valid;
    logic [31:0]   res_data;
    logic          res_last, busy, done, err;

    always #5 clk = ~clk;

    matmul_host_streamer #(
        .MAX_M(MX), .MAX_K(MX), .MAX_N(MX), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .M_cfg(m_cfg), .K_cfg(k_cfg), .N_cfg(n_cfg),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .acc_M(acc_m), .acc_K(acc_k), .acc_N(acc_n),
        .acc_serial_in(acc_serial_in), .acc_mode(acc_mode),
        .acc_serial_out(acc_serial_out), .acc_active(acc_active),
        .acc_done(acc_done),
        .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
        .busy(busy), .done(done), .err(err)
    );

    int    checks = 0;
    int    errors = 0;
    string cur_tag = "init";

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0d expected %0d", cur_tag, name, act, exp);
        end
    endtask

    // Passive observer of the accelerator pins and result stream.
    int          cyc = 0;
    logic [31:0] a_seen[$], b_seen[$], r_data[$];
    logic        r_last[$];
    logic [1:0]  mlog[$];
    int fin_cnt, fin_sin_bad, done_cnt, err_cnt, fin_cyc, done_cyc;
    logic done_err;

    always @(negedge clk) begin
        cyc++;
        mlog.push_back(acc_mode);
        if (acc_mode == 2'b01) a_seen.push_back(acc_serial_in);
        if (acc_mode == 2'b10) b_seen.push_back(acc_serial_in);
        if (acc_mode == 2'b11) begin
            fin_cnt++;
            fin_cyc = cyc;
            if (acc_serial_in != 0) fin_sin_bad++;
        end
        if (res_valid) begin
            r_data.push_back(res_data);
            r_last.push_back(res_last);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err;
        end
        if (err) err_cnt++;
    end

    task automatic clear_mon();
        a_seen.delete(); b_seen.delete(); r_data.delete();
        r_last.delete(); mlog.delete();
        fin_cnt = 0; fin_sin_bad = 0; done_cnt = 0; err_cnt = 0;
        fin_cyc = 0; done_cyc = 0; done_err = 1'b0;
    endtask

    logic [31:0] pre_a[16], pre_b[16];

    task automatic pulse_start(input int m, input int k, input int n);
        @(posedge clk); #1;
        start = 1'b1;
        m_cfg = DW'(m); k_cfg = DW'(k); n_cfg = DW'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_job(input int m, input int k, input int n,
                           input int gap, input int cmode, input int fixed,
                           input logic exp_err, input string tag);
        logic [31:0] ops[$];
        logic [31:0] cw[$];
        logic [1:0]  emode[$];
        logic [31:0] s;
        int mk, kn, mn, idx, c, nw, lim, bad, f, rdy_bad;
        logic v, ok;
        cur_tag = tag;
        mk = m * k; kn = k * n; mn = m * n;
        for (int i = 0; i < mk + kn; i++) begin
            if (fixed == 1)      ops.push_back(32'(i + 1));
            else if (fixed == 2) ops.push_back(i < mk ? pre_a[i] : pre_b[i - mk]);
            else                 ops.push_back($urandom_range(0, 1000));
        end
        clear_mon();
        pulse_start(m, k, n);
        if (cmode == REJ) begin
            @(negedge clk);
            chk("rej_err", err, 1);
            chk("rej_busy", busy, 0);
            chk("rej_rdy", in_ready, 0);
            chk("rej_acck", acc_k, k);
            @(posedge clk); #1;
            @(negedge clk);
            chk("rej_pulse", {err, busy}, 0);
            return;
        end
        idx = 0; c = 0; rdy_bad = 0; lim = 4 * (mk + kn) + 10;
        while (idx < mk + kn && c < lim) begin
            if (gap == 0)      v = 1'b1;
            else if (gap == 1) v = (c % 2 == 0);
            else               v = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = ops[idx];
            emode.push_back(!v ? 2'b00 : (idx < mk ? 2'b01 : 2'b10));
            @(negedge clk);
            if (!in_ready) rdy_bad++;
            ok = in_ready && v;
            @(posedge clk); #1;
            if (ok) idx++;
            c++;
        end
        in_valid = 1'b0;
        emode.push_back(2'b11);
        emode.push_back(2'b00);
        chk("load_done", idx, mk + kn);
        chk("in_ready", rdy_bad, 0);

        lim = 0;
        while (fin_cnt == 0 && lim < 20) begin
            @(negedge clk);
            lim++;
        end
        chk("fin_seen", fin_cnt > 0, 1);

        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int t = 0; t < k; t++)
                    s += ops[i * k + t] * ops[mk + t * n + j];
                cw.push_back(s);
            end
        if (cmode == EXTRA) cw.push_back($urandom);
        nw = (cmode == SHORT) ? mn - 1 : (cmode == TOUT) ? 0 : cw.size();

        for (int w = 0; w < nw; w++) begin
            if (gap == 2 && $urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                acc_active = 1'b0;
                acc_done   = 1'b0;
            end
            @(posedge clk); #1;
            acc_active     = 1'b1;
            acc_serial_out = cw[w];
            acc_done       = (cmode == DLAST) && (w == nw - 1);
        end
        if (cmode != TOUT) begin
            if (cmode != DLAST) begin
                @(posedge clk); #1;
                acc_active = 1'b0;
                acc_done   = 1'b1;
            end
            @(posedge clk); #1;
            acc_active = 1'b0;
            acc_done   = 1'b0;
            @(negedge clk);
            chk("done_lat", done, 1);
            if (cmode == DLAST) chk("last_w_done", {res_valid, res_last}, 2'b11);
        end
        lim = 0;
        while (done_cnt == 0 && lim < 3 * TO) begin
            @(negedge clk);
            lim++;
        end
        if (cmode == TOUT) chk("timeout_lat", done_cyc - fin_cyc, TO);
        repeat (2) @(negedge clk);
        chk("idle_busy", {busy, in_ready}, 0);

        bad = (a_seen.size() != mk);
        for (int i = 0; i < mk && i < a_seen.size(); i++)
            if (a_seen[i] !== ops[i]) bad++;
        chk("a_stream", bad, 0);
        bad = (b_seen.size() != kn);
        for (int i = 0; i < kn && i < b_seen.size(); i++)
            if (b_seen[i] !== ops[mk + i]) bad++;
        chk("b_stream", bad, 0);
        chk("fin_cnt", fin_cnt, 1);
        chk("fin_sin", fin_sin_bad, 0);

        f = -1; bad = 0;
        foreach (mlog[i]) if (f < 0 && mlog[i] != 2'b00) f = i;
        if (f < 0 || f + emode.size() > mlog.size()) bad = 1;
        else foreach (emode[j]) if (mlog[f + j] !== emode[j]) bad++;
        chk("mode_seq", bad, 0);

        chk("res_cnt", r_data.size(), nw);
        bad = 0;
        for (int i = 0; i < nw && i < r_data.size(); i++) begin
            if (r_data[i] !== cw[i]) bad++;
            if (r_last[i] !== (i == mn - 1)) bad++;
        end
        chk("res_words", bad, 0);
        chk("done_cnt", done_cnt, 1);
        chk("done_err", done_err, exp_err);
        chk("err_cnt", err_cnt, exp_err ? 1 : 0);
    endtask

    typedef struct {
        int   m, k, n, gap, cmode, fixed;
        logic exp_err;
    } vec_t;

    vec_t        tbl[10];
    logic [31:0] c0[4];
    int          rm, rk, rn, rc;

    initial begin
        tbl[0] = '{2, 3, 2, 0, NORM,  1, 1'b0};
        tbl[1] = '{2, 3, 2, 1, NORM,  1, 1'b0};
        tbl[2] = '{2, 0, 2, 0, REJ,   0, 1'b1};
        tbl[3] = '{5, 1, 1, 0, REJ,   0, 1'b1};
        tbl[4] = '{2, 3, 2, 0, DLAST, 1, 1'b0};
        tbl[5] = '{2, 3, 2, 0, SHORT, 1, 1'b1};
        tbl[6] = '{1, 2, 1, 0, TOUT,  0, 1'b1};
        tbl[7] = '{2, 2, 2, 2, EXTRA, 0, 1'b1};
        tbl[8] = '{4, 4, 4, 2, NORM,  0, 1'b0};
        tbl[9] = '{1, 1, 1, 0, NORM,  0, 1'b0};
        c0[0] = 58; c0[1] = 64; c0[2] = 139; c0[3] = 154;

        repeat (3) @(negedge clk);
        chk("reset_outs", {in_ready, acc_m, acc_k, acc_n, acc_serial_in,
                           acc_mode, res_valid, res_data, res_last,
                           busy, done, err}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_job(tbl[i].m, tbl[i].k, tbl[i].n, tbl[i].gap, tbl[i].cmode,
                    tbl[i].fixed, tbl[i].exp_err, $sformatf("row%0d", i));
            if (i == 0)
                for (int j = 0; j < 4; j++)
                    chk($sformatf("c_const%0d", j),
                        j < r_data.size() ? r_data[j] : 32'hdead, c0[j]);
        end

        for (int i = 0; i < 6; i++) begin
            rm = $urandom_range(1, MX);
            rk = $urandom_range(1, MX);
            rn = $urandom_range(1, MX);
            rc = $urandom_range(0, 1);
            run_job(rm, rk, rn, 2, rc, 0, 1'b0, $sformatf("rand%0d", i));
        end

        cur_tag = "mid_reset";
        clear_mon();
        pulse_start(2, 2, 2);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(100 + i);
            @(posedge clk); #1;
        end
        chk("busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {in_ready, acc_m, acc_k, acc_n, acc_serial_in,
                          acc_mode, res_valid, res_data, res_last,
                          busy, done, err}, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        pre_a[0] = 3;
        pre_b[0] = 4;
        run_job(1, 1, 1, 0, NORM, 2, 1'b0, "after_rst");
        chk("c_1x1", r_data.size() > 0 ? r_data[0] : 32'hdead, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_host_streamer.md
Name: matmul_host_streamer

Overview:
- Host-side driver for the matrix-multiply accelerator's serial interface.
- Accepts A and B operand words on a valid/ready stream and serialises them onto the accelerator's Serial_in/mode pins.
- Issues the finish code, then collects the accelerator's C words from Serial_out into a result stream.
- Sits between a DMA/testbench producer and the accelerator top.

Parameters:
- MAX_M, 100, max rows of A/C
- MAX_K, 100, max cols of A / rows of B
- MAX_N, 100, max cols of B/C
- TIMEOUT_CYCLES, 65535, idle cycles tolerated while awaiting C words before error

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a job (sampled in IDLE only)
- M_cfg  in  $clog2(MAX_M)+1  job M
- K_cfg  in  $clog2(MAX_K)+1  job K
- N_cfg  in  $clog2(MAX_N)+1  job N
- in_valid  in  1  operand word valid
- in_data  in  32  operand word: A row-major, then B row-major
- in_ready  out  1  operand word accepted when in_valid&&in_ready
- acc_M, acc_K, acc_N  out  same widths as *_cfg  latched dims to accelerator
- acc_serial_in  out  32  to accelerator Serial_in
- acc_mode  out  2  00 idle, 01 load A, 10 load B, 11 finish
- acc_serial_out  in  32  from accelerator Serial_out
- acc_active  in  1  accelerator C word valid
- acc_done  in  1  accelerator output complete pulse
- res_valid  out  1  result word valid (no backpressure)
- res_data  out  32  result word, C row-major
- res_last  out  1  with final C word
- busy  out  1  high outside IDLE
- done  out  1  one-cycle job-complete pulse
- err  out  1  one-cycle error pulse, coincident with done or a rejected start

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; acc_mode=00. Reset mid-job aborts immediately.
- Accelerator protocol (fixed): one word captured per cycle with mode 01/10; mode 00 cycles are ignored; one mode 11 cycle triggers the multiply. C words are streamed one per cycle while active; done pulses at end.
- IDLE: on start, latch M/K/N into acc_M/K/N.
  - Any dim zero or above its MAX → err pulse, remain IDLE.
  - Otherwise → LOAD_A. start outside IDLE is ignored.
- in_ready = 1 only in LOAD_A and LOAD_B (decoded from registered state/counters).
- LOAD_A: each accepted word → next edge acc_serial_in=in_data, acc_mode=01. Cycles with no handshake → acc_mode=00, acc_serial_in holds. After M*K accepts → LOAD_B.
- LOAD_B: same as LOAD_A with acc_mode=10. After K*N accepts → FINISH.
- FINISH: acc_mode=11 for exactly one cycle, acc_serial_in=0 → WAIT_C.
- WAIT_C / DRAIN:
  - acc_mode=00.
  - Each cycle with acc_active: next edge res_valid=1, res_data=acc_serial_out, res_count++.
  - res_last=1 when res_count==M*N-1.
  - First active word moves WAIT_C → DRAIN.
- acc_done (in either state, including the same cycle as the final active word; that word is still captured) → DONE.
- DONE: done=1 for one cycle. err=1 if captured count != M*N. → IDLE.
- Timeout: idle counter runs in WAIT_C/DRAIN and clears on each active word. Reaching TIMEOUT_CYCLES → done+err pulse, IDLE.
- Extra active words beyond M*N are forwarded with res_last=0 and flagged as err at DONE.
- Counter widths: $clog2(MAX_M*MAX_K+1), $clog2(MAX_K*MAX_N+1), $clog2(MAX_M*MAX_N+1). Products are computed at latch time into registers.
- Latency: operand word to acc_serial_in is 1 cycle; acc_serial_out to res_data is 1 cycle.

Test Plan:
- M=2,K=3,N=2, in_valid held high, A=1..6, B=7..12:
  - acc_mode sequence is 01×6, 10×6, 11×1, then 00.
  - acc_serial_in follows 1..12 one cycle after each accept.
  - Model accelerator returns C={58,64,139,154}: res_data matches, res_last on 154, done one cycle after acc_done, err=0.
- Same job with in_valid toggled 1,0,1,0 → acc_mode=00 on gap cycles; word order and counts unchanged.
- start with K_cfg=0 → err pulse next cycle, busy stays 0, in_ready 0.
- Model asserts acc_done together with the 4th C word → word captured with res_last=1, done the following cycle, err=0. Model giving only 3 words → done+err.
- Model never asserts active, TIMEOUT_CYCLES=16 → done and err pulse exactly 16 cycles after WAIT_C entry; back to IDLE.
- Assert rst_n low during LOAD_B → all outputs 0 asynchronously. Next start runs a fresh 1×1×1 job (A=3, B=4, C=12) correctly.
